// File: rtl/aud_cic_interp.sv
// CIC interpolator: pulls input samples at the low rate and emits OUT_DIV-spaced output samples.
// Define AUD_CIC_INTERP_SAT_EN to clamp the scaled output instead of wrapping it.
module aud_cic_interp #(
  parameter int unsigned N_STAGES = 3,
  parameter int unsigned LOG2R    = 6,
  parameter int unsigned IN_W     = 16,
  parameter int unsigned OUT_W    = 16,
  parameter int unsigned OUT_DIV  = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    in_tick,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    in_req,
  input  logic [2:0]              gain_sel,
  input  logic                    clr_flags,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_tick,
  output logic                    underrun,
  output logic                    overrun
);

  localparam int unsigned W     = IN_W + N_STAGES * LOG2R;
  localparam int unsigned SHIFT = (N_STAGES - 1) * LOG2R;
  localparam int unsigned SH_W  = $clog2(SHIFT + 1);
  localparam int unsigned DIV_W = (OUT_DIV > 1) ? $clog2(OUT_DIV) : 1;

  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic [LOG2R-1:0]        phase_cnt_q, phase_cnt_d;
  logic signed [IN_W-1:0]  hold_q, hold_d;
  logic                    hold_valid_q, hold_valid_d;
  logic signed [IN_W-1:0]  last_q, last_d;
  logic signed [W-1:0]     comb_dly_q [N_STAGES];
  logic signed [W-1:0]     comb_dly_d [N_STAGES];
  logic signed [W-1:0]     integ_q [N_STAGES];
  logic signed [W-1:0]     integ_d [N_STAGES];
  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic                    out_tick_q, out_tick_d;
  logic                    in_req_q, in_req_d;
  logic                    underrun_q, underrun_d;
  logic                    overrun_q, overrun_d;

  logic                    slot, consume, under_set, over_set;
  logic signed [IN_W-1:0]  x;
  logic signed [W-1:0]     stage_in, u;
  logic [SH_W-1:0]         shamt;
  logic signed [OUT_W-1:0] out_val;
`ifdef AUD_CIC_INTERP_SAT_EN
  localparam logic signed [W-1:0] SAT_MAX = {{(W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {{(W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};
  logic signed [W-1:0]     scaled;
`endif

  // Next-state logic: rate counters, hold buffer, combs, integrators, scaling, flags.
  always_comb begin
    div_cnt_d    = div_cnt_q;
    phase_cnt_d  = phase_cnt_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    last_d       = last_q;
    comb_dly_d   = comb_dly_q;
    integ_d      = integ_q;
    out_data_d   = out_data_q;
    under_set    = 1'b0;
    over_set     = 1'b0;
    x            = last_q;
    out_val      = '0;
`ifdef AUD_CIC_INTERP_SAT_EN
    scaled       = '0;
`endif

    slot    = (div_cnt_q == DIV_W'(OUT_DIV - 1));
    consume = slot && (phase_cnt_q == '0);

    div_cnt_d = slot ? '0 : div_cnt_q + DIV_W'(1);
    if (slot) phase_cnt_d = phase_cnt_q + LOG2R'(1);

    // A tick on the consume cycle bypasses the buffer and drops any held sample.
    if (consume) begin
      hold_valid_d = 1'b0;
      if (in_tick)           x = in_data;
      else if (hold_valid_q) x = hold_q;
      else                   under_set = 1'b1;
      last_d = x;
    end else if (in_tick) begin
      hold_d       = in_data;
      hold_valid_d = 1'b1;
      over_set     = hold_valid_q;
    end

    stage_in = {{(W - IN_W){x[IN_W-1]}}, x};
    for (int i = 0; i < int'(N_STAGES); i++) begin
      if (consume) comb_dly_d[i] = stage_in;
      stage_in = stage_in - comb_dly_q[i];
    end
    u = consume ? stage_in : '0;

    // Pipelined integrators: each stage adds the previous stage's pre-update value.
    if (slot) begin
      integ_d[0] = integ_q[0] + u;
      for (int i = 1; i < int'(N_STAGES); i++) begin
        integ_d[i] = integ_q[i] + integ_q[i-1];
      end
    end

    shamt = SH_W'(SHIFT) - SH_W'(gain_sel);
`ifdef AUD_CIC_INTERP_SAT_EN
    scaled = integ_q[N_STAGES-1] >>> shamt;
    if (scaled > SAT_MAX)      out_val = SAT_MAX[OUT_W-1:0];
    else if (scaled < SAT_MIN) out_val = SAT_MIN[OUT_W-1:0];
    else                       out_val = scaled[OUT_W-1:0];
`else
    out_val = OUT_W'(integ_q[N_STAGES-1] >>> shamt);
`endif
    if (slot) out_data_d = out_val;

    out_tick_d = slot;
    in_req_d   = consume;
    underrun_d = (underrun_q & ~clr_flags) | under_set;
    overrun_d  = (overrun_q & ~clr_flags) | over_set;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_cnt_q    <= '0;
      phase_cnt_q  <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      last_q       <= '0;
      for (int i = 0; i < int'(N_STAGES); i++) begin
        comb_dly_q[i] <= '0;
        integ_q[i]    <= '0;
      end
      out_data_q   <= '0;
      out_tick_q   <= 1'b0;
      in_req_q     <= 1'b0;
      underrun_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      phase_cnt_q  <= phase_cnt_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      last_q       <= last_d;
      comb_dly_q   <= comb_dly_d;
      integ_q      <= integ_d;
      out_data_q   <= out_data_d;
      out_tick_q   <= out_tick_d;
      in_req_q     <= in_req_d;
      underrun_q   <= underrun_d;
      overrun_q    <= overrun_d;
    end
  end

  assign out_data = out_data_q;
  assign out_tick = out_tick_q;
  assign in_req   = in_req_q;
  assign underrun = underrun_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_aud_cic_interp.sv
// Bench for aud_cic_interp: expected outputs come from the CIC impulse response (boxcar^N)
// convolved with the consumed sample sequence, plus a sample-buffer/flag model.
module tb_aud_cic_interp;

  localparam int N       = 3;
  localparam int LOG2R   = 6;
  localparam int R       = 1 << LOG2R;
  localparam int OUT_DIV = 2;
  localparam int SHIFT   = (N - 1) * LOG2R;
  localparam int HLEN    = N * (R - 1) + 1;
  localparam int PER     = R * OUT_DIV;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_tick;
  logic [15:0] in_data;
  logic        in_req;
  logic [2:0]  gain_sel;
  logic        clr_flags;
  logic [15:0] out_data;
  logic        out_tick;
  logic        underrun;
  logic        overrun;

  aud_cic_interp dut (
    .CLK(CLK), .RST(RST), .in_tick(in_tick), .in_data(in_data), .in_req(in_req),
    .gain_sel(gain_sel), .clr_flags(clr_flags), .out_data(out_data), .out_tick(out_tick),
    .underrun(underrun), .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  longint h [HLEN];
  int     xs [$];
  int     cyc, pend, last_x, next_tick, next_tick2, prod_val;
  bit     pend_v, resp_en, skip_one, rand_mode, clr_req;
  bit     e_under, e_over, e_req, e_tick;
  logic signed [15:0] e_out;
  int     passes, checks;

  // Impulse response of N cascaded length-R boxcars.
  task automatic build_h();
    longint a [HLEN];
    longint b [HLEN];
    for (int n = 0; n < HLEN; n++) a[n] = (n < R) ? 1 : 0;
    repeat (N - 1) begin
      for (int n = 0; n < HLEN; n++) begin
        b[n] = 0;
        for (int j = 0; j < R; j++) if (n - j >= 0) b[n] += a[n-j];
      end
      a = b;
    end
    h = a;
  endtask

  function automatic logic signed [15:0] model_out(int t, int g);
    longint y, s;
    int n;
    y = 0;
    foreach (xs[k]) begin
      n = t - N - R * k;
      if (n >= 0 && n < HLEN) y += longint'(xs[k]) * h[n];
    end
    s = y >>> (SHIFT - g);
`ifdef AUD_CIC_INTERP_SAT_EN
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`endif
    return 16'(s);
  endfunction

  // One clock: apply inputs, advance, then update the reference model.
  task automatic step(input bit tk, input int dv, input bit clr);
    bit slot, cons, un, ov;
    int t, x, r;
    in_tick = tk; in_data = 16'(dv); clr_flags = clr;
    @(posedge CLK);
    @(negedge CLK);
    in_tick = 1'b0; clr_flags = 1'b0;
    cyc++;
    slot = (cyc % OUT_DIV) == 0;
    t = cyc / OUT_DIV - 1;
    cons = slot && (t % R == 0);
    un = 0; ov = 0;
    if (cons) begin
      if (tk) x = dv;
      else if (pend_v) x = pend;
      else begin x = last_x; un = 1; end
      pend_v = 0; last_x = x; xs.push_back(x);
    end else if (tk) begin
      if (pend_v) ov = 1;
      pend = dv; pend_v = 1;
    end
    e_under = (e_under & ~clr) | un;
    e_over  = (e_over & ~clr) | ov;
    e_req = cons; e_tick = slot;
    if (slot) e_out = model_out(t, int'(gain_sel));
    if (cons && resp_en) begin
      next_tick2 = -1;
      if (skip_one) begin skip_one = 0; next_tick = -1; end
      else if (rand_mode) begin
        r = int'($urandom_range(0, 9));
        if (r == 0) next_tick = -1;
        else if (r == 1) next_tick = cyc + PER;
        else if (r == 2) begin
          next_tick = cyc + int'($urandom_range(1, 60));
          next_tick2 = next_tick + int'($urandom_range(1, 60));
        end else next_tick = cyc + int'($urandom_range(1, PER - 2));
      end else next_tick = cyc + int'($urandom_range(1, PER - 2));
    end
  endtask

  task automatic prod_step();
    bit tk;
    tk = (cyc + 1 == next_tick) || (cyc + 1 == next_tick2);
    if (tk && rand_mode) prod_val = int'($urandom_range(0, 65535)) - 32768;
    step(tk, prod_val, clr_req);
    clr_req = 0;
  endtask

  task automatic reset_dut();
    RST = 1; in_tick = 0; clr_flags = 0;
    @(posedge CLK);
    @(negedge CLK);
    RST = 0;
    cyc = 0; xs.delete(); pend_v = 0; pend = 0; last_x = 0;
    e_under = 0; e_over = 0; e_req = 0; e_tick = 0; e_out = '0;
    skip_one = 0; clr_req = 0; next_tick2 = -1;
    next_tick = resp_en ? 1 : -1;
  endtask

  task automatic test_reset();
    resp_en = 0;
    reset_dut();
    checks++;
    if ({out_data, out_tick, in_req, underrun, overrun} !== 20'h0) begin
      $display("FAIL reset_state got %h want 0", {out_data, out_tick, in_req, underrun, overrun});
    end else passes++;
    repeat (2) prod_step();
    checks++;
    if ({out_tick, in_req, underrun, overrun} !== 4'b1110) begin
      $display("FAIL first_consume_underrun got tk/rq/un/ov=%b want 1110", {out_tick, in_req, underrun, overrun});
    end else passes++;
  endtask

  task automatic test_dc();
    int rq_prev, rq_last;
    rq_prev = -1; rq_last = -1;
    resp_en = 1; prod_val = 1000; gain_sel = 0;
    reset_dut();
    for (int i = 0; i < 600; i++) begin
      prod_step();
      if (in_req) begin rq_prev = rq_last; rq_last = cyc; end
      checks++;
      if ({out_data, out_tick, in_req, underrun, overrun} !== {e_out, e_tick, e_req, e_under, e_over}) begin
        $display("FAIL dc cyc=%0d got out=%0d tk/rq/un/ov=%b want out=%0d tk/rq/un/ov=%b", cyc,
                 $signed(out_data), {out_tick, in_req, underrun, overrun}, e_out, {e_tick, e_req, e_under, e_over});
      end else passes++;
    end
    checks++;
    if ({out_data, underrun, overrun} !== {16'd1000, 2'b00}) begin
      $display("FAIL dc_settle got out=%0d un=%b ov=%b want 1000 0 0", $signed(out_data), underrun, overrun);
    end else passes++;
    checks++;
    if (rq_last - rq_prev !== PER) begin
      $display("FAIL dc_req_period got %0d want %0d", rq_last - rq_prev, PER);
    end else passes++;
  endtask

  task automatic test_gain();
    logic [15:0] want;
    resp_en = 1; prod_val = 1000; gain_sel = 3;
    reset_dut();
    for (int ph = 0; ph < 2; ph++) begin
      if (ph == 1) begin prod_val = -1000; gain_sel = 7; end
      for (int i = 0; i < 600; i++) begin
        prod_step();
        checks++;
        if ({out_data, out_tick, in_req, underrun, overrun} !== {e_out, e_tick, e_req, e_under, e_over}) begin
          $display("FAIL gain cyc=%0d got out=%0d tk/rq/un/ov=%b want out=%0d tk/rq/un/ov=%b", cyc,
                   $signed(out_data), {out_tick, in_req, underrun, overrun}, e_out, {e_tick, e_req, e_under, e_over});
        end else passes++;
      end
`ifdef AUD_CIC_INTERP_SAT_EN
      want = (ph == 0) ? 16'd8000 : 16'h8000;
`else
      want = (ph == 0) ? 16'd8000 : 16'd3072;
`endif
      checks++;
      if (out_data !== want) begin
        $display("FAIL gain_settle ph=%0d got %0d want %0d", ph, $signed(out_data), $signed(want));
      end else passes++;
    end
    gain_sel = 0;
  endtask

  task automatic test_impulse();
    int first_nz, last_nz, t;
    longint sum;
    first_nz = -1; last_nz = -1; sum = 0;
    resp_en = 1; prod_val = 4096; gain_sel = 0;
    reset_dut();
    for (int i = 0; i < 430; i++) begin
      prod_step();
      if (i == 0) prod_val = 0;
      if (e_tick) begin
        t = cyc / OUT_DIV - 1;
        sum += longint'($signed(out_data));
        if (out_data != 0) begin
          if (first_nz < 0) first_nz = t;
          last_nz = t;
        end
      end
      checks++;
      if ({out_data, out_tick, in_req, underrun, overrun} !== {e_out, e_tick, e_req, e_under, e_over}) begin
        $display("FAIL impulse cyc=%0d got out=%0d tk/rq/un/ov=%b want out=%0d tk/rq/un/ov=%b", cyc,
                 $signed(out_data), {out_tick, in_req, underrun, overrun}, e_out, {e_tick, e_req, e_under, e_over});
      end else passes++;
    end
    checks++;
    if (first_nz !== N || last_nz !== N + N * (R - 1)) begin
      $display("FAIL impulse_span got %0d..%0d want %0d..%0d", first_nz, last_nz, N, N + N * (R - 1));
    end else passes++;
    checks++;
    if (sum !== 64'(R * R * R)) begin
      $display("FAIL impulse_sum got %0d want %0d", sum, R * R * R);
    end else passes++;
  endtask

  task automatic test_underrun();
    resp_en = 1; prod_val = 1000; gain_sel = 0;
    reset_dut();
    for (int i = 0; i < 1200; i++) begin
      if (i == 500) skip_one = 1;
      if (i == 900) clr_req = 1;
      if (i > 1000) clr_req = !e_under && ((cyc + 1) % PER == 2);
      if (i == 1000) skip_one = 1;
      prod_step();
      checks++;
      if ({out_data, out_tick, in_req, underrun, overrun} !== {e_out, e_tick, e_req, e_under, e_over}) begin
        $display("FAIL underrun cyc=%0d got out=%0d tk/rq/un/ov=%b want out=%0d tk/rq/un/ov=%b", cyc,
                 $signed(out_data), {out_tick, in_req, underrun, overrun}, e_out, {e_tick, e_req, e_under, e_over});
      end else passes++;
      if (i == 850) begin
        checks++;
        if ({out_data, underrun} !== {16'd1000, 1'b1}) begin
          $display("FAIL underrun_hold got out=%0d un=%b want 1000 1", $signed(out_data), underrun);
        end else passes++;
      end
      if (i == 900) begin
        checks++;
        if (underrun !== 1'b0) $display("FAIL underrun_clear got %b want 0", underrun);
        else passes++;
      end
    end
    checks++;
    if ({out_data, underrun} !== {16'd1000, 1'b1}) begin
      $display("FAIL underrun_set_wins got out=%0d un=%b want 1000 1", $signed(out_data), underrun);
    end else passes++;
  endtask

  task automatic test_overrun_bypass();
    resp_en = 1; prod_val = 1000; gain_sel = 0;
    reset_dut();
    for (int seg = 0; seg < 5; seg++) begin
      if (seg == 1) begin resp_en = 0; next_tick = -1; prod_val = 100; next_tick = cyc + 5; end
      if (seg == 2) begin next_tick = cyc + PER; prod_val = 300; end
      if (seg == 3) clr_req = 1;
      if (seg == 4) begin next_tick = cyc + 10; prod_val = 400; end
      for (int i = 0; i < ((seg == 3) ? 1 : 700); i++) begin
        if (seg == 1 && cyc + 1 == next_tick + 1) begin prod_val = 200; next_tick = cyc + 10; end
        prod_step();
        checks++;
        if ({out_data, out_tick, in_req, underrun, overrun} !== {e_out, e_tick, e_req, e_under, e_over}) begin
          $display("FAIL overrun cyc=%0d got out=%0d tk/rq/un/ov=%b want out=%0d tk/rq/un/ov=%b", cyc,
                   $signed(out_data), {out_tick, in_req, underrun, overrun}, e_out, {e_tick, e_req, e_under, e_over});
        end else passes++;
        if (e_req && seg != 0) break;
        if (e_req && seg == 0 && i > 500) break;
      end
      if (seg != 3) begin
        checks++;
        if (in_req !== 1'b1) $display("FAIL overrun_sync seg=%0d got in_req=%b want 1", seg, in_req);
        else passes++;
      end
      checks++;
      if ({underrun, overrun} !== ((seg == 1 || seg == 2) ? 2'b01 : 2'b00)) begin
        $display("FAIL overrun_flags seg=%0d got un/ov=%b want %b", seg, {underrun, overrun},
                 (seg == 1 || seg == 2) ? 2'b01 : 2'b00);
      end else passes++;
    end
  endtask

  task automatic test_reset_mid();
    resp_en = 1; prod_val = 1000; gain_sel = 0;
    reset_dut();
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 530; i++) begin
        prod_step();
        checks++;
        if ({out_data, out_tick, in_req, underrun, overrun} !== {e_out, e_tick, e_req, e_under, e_over}) begin
          $display("FAIL reset_mid cyc=%0d got out=%0d tk/rq/un/ov=%b want out=%0d tk/rq/un/ov=%b", cyc,
                   $signed(out_data), {out_tick, in_req, underrun, overrun}, e_out, {e_tick, e_req, e_under, e_over});
        end else passes++;
      end
      checks++;
      if (out_data !== 16'd1000) $display("FAIL reset_mid_settle ph=%0d got %0d want 1000", ph, $signed(out_data));
      else passes++;
      if (ph == 0) begin
        reset_dut();
        checks++;
        if ({out_data, out_tick, in_req, underrun, overrun} !== 20'h0) begin
          $display("FAIL reset_mid_clear got %h want 0", {out_data, out_tick, in_req, underrun, overrun});
        end else passes++;
      end
    end
  endtask

  task automatic test_random();
    resp_en = 1; rand_mode = 1; prod_val = 0; gain_sel = 0;
    reset_dut();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) gain_sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 63) == 0) clr_req = 1;
      prod_step();
      checks++;
      if ({out_data, out_tick, in_req, underrun, overrun} !== {e_out, e_tick, e_req, e_under, e_over}) begin
        $display("FAIL random cyc=%0d got out=%0d tk/rq/un/ov=%b want out=%0d tk/rq/un/ov=%b", cyc,
                 $signed(out_data), {out_tick, in_req, underrun, overrun}, e_out, {e_tick, e_req, e_under, e_over});
      end else passes++;
    end
    rand_mode = 0; gain_sel = 0;
  endtask

  initial begin
    passes = 0; checks = 0;
    RST = 1; in_tick = 0; in_data = '0; gain_sel = '0; clr_flags = 0;
    rand_mode = 0; resp_en = 0; skip_one = 0; clr_req = 0;
    build_h();
    test_reset();
    test_dc();
    test_gain();
    test_impulse();
    test_underrun();
    test_overrun_bypass();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/aud_cic_interp.md
Name: aud_cic_interp

Overview:
Transmit-side counterpart of the receive decimation chain: a CIC interpolator that takes signed audio samples at the low rate and produces a signed sample stream at the modulator rate, for the NCO/upconversion path. Pull model: the block requests each input sample with a strobe and holds a one-deep buffer. Comb stages run at the input rate, zero-stuffing by R follows, and integrators run at the output rate.

Parameters:
N_STAGES, 3, number of comb and integrator stages (1..5)
LOG2R, 6, log2 of the interpolation ratio R (R=64)
IN_W, 16, input sample width, signed
OUT_W, 16, output sample width, signed
OUT_DIV, 2, CLK cycles per output slot (>=1)

Ports:
CLK  in  1  system clock
RST  in  1  reset, synchronous, active-high
in_tick  in  1  single-cycle strobe, in_data valid
in_data  in  IN_W  signed input sample
in_req  out  1  single-cycle pulse requesting the next input sample
gain_sel  in  3  output gain trim, x2^gain_sel
clr_flags  in  1  clears underrun/overrun
out_data  out  OUT_W  signed interpolated sample
out_tick  out  1  single-cycle strobe, out_data updated
underrun  out  1  sticky, input sample missing at consume point
overrun  out  1  sticky, buffered sample overwritten before use

Behaviour:
- Internal width W = IN_W + N_STAGES*LOG2R; all comb/integrator arithmetic is two's complement modulo 2^W, with no saturation. Wrap is required for correctness.
- div_cnt counts 0..OUT_DIV-1. A slot occurs on the cycle div_cnt==OUT_DIV-1. phase_cnt (LOG2R bits) increments on every slot and wraps R-1 -> 0.
- Hold buffer: in_tick loads hold and sets hold_valid. If in_tick arrives while hold_valid=1 and it is not a consume cycle, overwrite hold and set overrun.
- Consume: happens on a slot with phase_cnt==0.
  - If in_tick is high that cycle, in_data is used directly (bypass) and hold_valid is left 0.
  - Else if hold_valid=1, hold is used and hold_valid is cleared.
  - Else the previous consumed sample is reused and underrun is set.
- in_req pulses high on the cycle after each consume. The producer has R slots to deliver.
- Combs (differential delay 1): c0 = x - x_d, ci = c(i-1) - c(i-1)_d. Delay registers update only on consume. Input x is sign-extended to W.
- Integrator input u = comb output on a consume slot, else 0 (zero-stuffing).
- On each slot: I0 <= I0 + u, and Ii <= Ii + I(i-1) using the pre-update value (pipelined).
- Scaling: s = I(N-1) >>> ((N_STAGES-1)*LOG2R - gain_sel), arithmetic shift. (N_STAGES-1)*LOG2R must be >= 7; gain_sel=0 gives unity DC gain.
- On each slot: out_data <= OUT_W result of s, per the optional feature. out_tick is asserted the following cycle, for exactly 1 cycle, every OUT_DIV cycles.
- Latency: an impulse consumed at slot k first appears on out_data at slot k+N_STAGES, visible with the out_tick after that slot.
- Flags: clr_flags clears both flags. If a set event occurs in the same cycle as clr_flags, the set wins.
- Reset, at any time including mid-operation, clears all of the following:
  - counters, combs, integrators, hold, hold_valid
  - last sample
  - out_data=0, out_tick=0, in_req=0, underrun=0, overrun=0
  - The first slot after reset has phase_cnt=0 and consumes, so underrun sets if no sample has arrived.

Optional Feature:
Macro AUD_CIC_INTERP_SAT_EN.
- Defined: s is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Undefined: out_data takes the low OUT_W bits of s (wraps).

Test Plan:
- DC: reply to every in_req with 1000, gain_sel=0. out_data settles to exactly 1000 within N_STAGES*R+4 slots and stays there. underrun=0, overrun=0, in_req period = R*OUT_DIV = 128 clocks.
- Gain: DC 1000 with gain_sel=3 settles at 8000. DC -1000 with gain_sel=7 settles at -128000, which with SAT_EN reads -32768 and without it reads the low 16 bits (-62464 mod 2^16 = 3072).
- Impulse: input 4096 once, then zeros. The output sequence equals the R=64, N=3 CIC impulse response scaled >>12. First nonzero out_data is 3 slots after consume; the sequence returns to 0 after 3*64 slots.
- Underrun: withhold the response to one in_req. underrun=1 and the output continues the previous DC level. clr_flags clears underrun. Simultaneous clr_flags and underrun event leaves underrun=1.
- Overrun/bypass: two in_ticks (100 then 200) within one period gives overrun=1 and 200 is consumed. in_tick on a consume cycle uses in_data directly and hold_valid stays 0.
- Reset mid-stream: assert RST for 1 cycle during DC 1000. The next cycle shows out_data=0 and all flags 0. Re-settles to 1000 after restart.
